// File: rtl/aes_sub_bytes_masked_seq_if.sv
// Request/response bundle of the sequential masked SubBytes engine.
interface aes_sub_bytes_masked_seq_if;
  localparam int unsigned StateW = 128;
  localparam int unsigned SeedW  = 32;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [1:0]        op_i;
  logic [StateW-1:0] data_i;
  logic [StateW-1:0] mask_i;
  logic              seed_valid_i;
  logic [SeedW-1:0]  seed_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [StateW-1:0] data_o;
  logic [StateW-1:0] mask_o;
  logic              busy_o;

  modport slave (
    input  in_valid_i, op_i, data_i, mask_i, seed_valid_i, seed_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, mask_o, busy_o
  );

  modport master (
    output in_valid_i, op_i, data_i, mask_i, seed_valid_i, seed_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, mask_o, busy_o
  );
endinterface

// File: rtl/aes_sub_bytes_masked_seq.sv
// Byte-serial masked SubBytes/InvSubBytes engine with a per-byte LFSR output mask.

// Behavioural equivalent of the masked S-box: result is masked with prd_i, mask_o = prd_i.
module aes_sbox_canright_masked (
  input  logic [1:0] op_i,
  input  logic [7:0] data_i,
  input  logic [7:0] mask_i,
  input  logic [7:0] prd_i,
  output logic [7:0] data_o,
  output logic [7:0] mask_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] fwd_affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] unmasked;
  logic [7:0] sbox_out;

  always_comb begin
    unmasked = data_i ^ mask_i;
    if (op_i == 2'b10) sbox_out = gf_inv(inv_affine(unmasked));
    else               sbox_out = fwd_affine(gf_inv(unmasked));
  end

  assign data_o = sbox_out ^ prd_i;
  assign mask_o = prd_i;
endmodule

module aes_sub_bytes_masked_seq #(
  parameter logic [31:0] LfsrSeed = 32'hC0FF_EE01,
  parameter logic [31:0] LfsrPoly = 32'h8020_0003
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  aes_sub_bytes_masked_seq_if.slave   bus
);
  localparam int unsigned StateW   = 128;
  localparam int unsigned NumBytes = 16;
  localparam int unsigned CntW     = 4;
  localparam int unsigned LfsrW    = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic              accept;
  logic [CntW-1:0]   cnt_q;
  logic [LfsrW-1:0]  lfsr_q;
  logic [LfsrW-1:0]  lfsr_next;
  logic [1:0]        op_q;
  logic [StateW-1:0] data_q, mask_q;
  logic [StateW-1:0] res_data_q, res_mask_q;
  logic [6:0]        byte_idx;
  logic [7:0]        sb_data_in, sb_mask_in, sb_prd;
  logic [7:0]        sb_data_out, sb_mask_out;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid_i) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN:  if (cnt_q == CntW'(NumBytes - 1)) state_d = DONE;
      DONE: if (bus.out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign lfsr_next  = {1'b0, lfsr_q[LfsrW-1:1]} ^ (lfsr_q[0] ? LfsrPoly : '0);
  assign byte_idx   = {cnt_q, 3'b000};
  assign sb_data_in = data_q[byte_idx +: 8];
  assign sb_mask_in = mask_q[byte_idx +: 8];
  assign sb_prd     = lfsr_q[7:0];

  aes_sbox_canright_masked u_sbox (
    .op_i   (op_q),
    .data_i (sb_data_in),
    .mask_i (sb_mask_in),
    .prd_i  (sb_prd),
    .data_o (sb_data_out),
    .mask_o (sb_mask_out)
  );

  // Seeding and accept share IDLE so a same-cycle seed feeds the first RUN byte.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      lfsr_q     <= LfsrSeed;
      op_q       <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      res_data_q <= '0;
      res_mask_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.seed_valid_i) lfsr_q <= (bus.seed_i == '0) ? LfsrSeed : bus.seed_i;
          if (accept) begin
            data_q <= bus.data_i;
            mask_q <= bus.mask_i;
            op_q   <= bus.op_i;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          res_data_q[byte_idx +: 8] <= sb_data_out;
          res_mask_q[byte_idx +: 8] <= sb_mask_out;
          lfsr_q <= lfsr_next;
          cnt_q  <= cnt_q + CntW'(1);
        end
        DONE: if (bus.out_ready_i) begin
          data_q     <= '0;
          mask_q     <= '0;
          res_data_q <= '0;
          res_mask_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Result only leaves the block in DONE; partial state is never visible.
  assign bus.in_ready_o  = (state_q == IDLE);
  assign bus.busy_o      = (state_q == RUN) || (state_q == DONE);
  assign bus.out_valid_o = (state_q == DONE);
  assign bus.data_o      = (state_q == DONE) ? res_data_q : '0;
  assign bus.mask_o      = (state_q == DONE) ? res_mask_q : '0;
endmodule

// File: tb/tb_aes_sub_bytes_masked_seq.sv
// Randomized bench for aes_sub_bytes_masked_seq against a table-driven AES S-box model.
module tb_aes_sub_bytes_masked_seq;
  localparam logic [31:0] Seed = 32'hC0FF_EE01;
  localparam logic [31:0] Poly = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_sub_bytes_masked_seq_if bus();

  aes_sub_bytes_masked_seq #(.LfsrSeed(Seed), .LfsrPoly(Poly)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0]   sbox_t [256];
  logic [7:0]   inv_t  [256];
  logic [31:0]  lfsr_m;
  logic [127:0] last_mask, last_unmasked;
  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Forward table from the log/antilog walk over generator 3; inverse by table inversion.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) inv_t[sbox_t[i]] = 8'(i);
  endtask

  task automatic idle_inputs();
    bus.in_valid_i   = 1'b0;
    bus.seed_valid_i = 1'b0;
    bus.out_ready_i  = 1'b0;
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [127:0] d, input logic [127:0] m,
                         input logic sv, input logic [31:0] s, input int hold);
    logic [127:0] exp_d, exp_m, exp_u;
    logic [7:0] u;
    int cyc;
    check("ready_idle", 128'(bus.in_ready_o), 128'(1));
    if (sv) lfsr_m = (s == 32'h0) ? Seed : s;
    for (int i = 0; i < 16; i++) begin
      u = d[8*i +: 8] ^ m[8*i +: 8];
      exp_u[8*i +: 8] = (op == 2'b10) ? inv_t[u] : sbox_t[u];
      exp_m[8*i +: 8] = lfsr_m[7:0];
      lfsr_m = {1'b0, lfsr_m[31:1]} ^ (lfsr_m[0] ? Poly : 32'h0);
    end
    exp_d = exp_u ^ exp_m;
    bus.in_valid_i   = 1'b1;
    bus.op_i         = op;
    bus.data_i       = d;
    bus.mask_i       = m;
    bus.seed_valid_i = sv;
    bus.seed_i       = s;
    @(posedge clk); #1;
    idle_inputs();
    bus.data_i = 128'($urandom);
    cyc = 1;
    while (!bus.out_valid_o && cyc < 40) begin
      check("run_gate", bus.data_o | bus.mask_o, 128'(0));
      check("run_busy", {bus.busy_o, bus.in_ready_o}, 128'(2));
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 128'(cyc), 128'(17));
    last_mask     = bus.mask_o;
    last_unmasked = bus.data_o ^ bus.mask_o;
    check("mask_out", bus.mask_o, exp_m);
    check("data_out", bus.data_o, exp_d);
    check("unmasked", last_unmasked, exp_u);
    for (int h = 0; h < hold; h++) begin
      bus.in_valid_i   = 1'b1;
      bus.seed_valid_i = 1'b1;
      bus.seed_i       = $urandom | 32'h1;
      bus.data_i       = {4{$urandom}};
      @(posedge clk); #1;
      check("hold_data", bus.data_o, exp_d);
      check("hold_mask", bus.mask_o, exp_m);
      check("hold_flags", {bus.out_valid_o, bus.busy_o, bus.in_ready_o}, 128'(6));
    end
    bus.in_valid_i   = 1'b0;
    bus.seed_valid_i = 1'b0;
    bus.out_ready_i  = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    check("release_out", bus.data_o | bus.mask_o, 128'(0));
    check("release_flags", {bus.out_valid_o, bus.busy_o, bus.in_ready_o}, 128'(1));
  endtask

  initial begin
    logic [127:0] m, pt, d;
    rst = 1'b1;
    idle_inputs();
    bus.op_i   = 2'b01;
    bus.data_i = '0;
    bus.mask_i = '0;
    bus.seed_i = '0;
    build_tables();
    lfsr_m = Seed;
    #1;
    check("rst_out", bus.data_o | bus.mask_o, 128'(0));
    check("rst_flags", {bus.out_valid_o, bus.busy_o, bus.in_ready_o}, 128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(2'b01, '0, '0, 1'b0, 32'h0, 0);
    check("enc_zero_const", last_unmasked, {16{8'h63}});

    run_txn(2'b01, {16{8'hF6}}, {16{8'hA5}}, 1'b0, 32'h0, 1);
    check("enc_53_const", last_unmasked, {16{8'hED}});
    run_txn(2'b11, {16{8'hF6}}, {16{8'hA5}}, 1'b0, 32'h0, 0);
    check("op11_const", last_unmasked, {16{8'hED}});

    m = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 16; i++) pt[8*i +: 8] = i[0] ? 8'hED : 8'h63;
    run_txn(2'b10, pt ^ m, m, 1'b0, 32'h0, 0);
    check("dec_const", last_unmasked, {8{8'h53, 8'h00}});

    run_txn(2'b01, {4{$urandom}}, {4{$urandom}}, 1'b1, 32'h1, 5);
    check("seed1_bytes", 128'(last_mask[23:0]), 128'(24'h020301));
    run_txn(2'b01, {4{$urandom}}, {4{$urandom}}, 1'b1, 32'h0, 0);
    check("seed0_byte", 128'(last_mask[7:0]), 128'(8'h01));

    // Reset in the middle of RUN, with cnt at 7
    d = {4{$urandom}};
    bus.in_valid_i = 1'b1;
    bus.op_i       = 2'b01;
    bus.data_i     = d;
    bus.mask_i     = '0;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out", bus.data_o | bus.mask_o, 128'(0));
    check("midrst_flags", {bus.out_valid_o, bus.busy_o, bus.in_ready_o}, 128'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    lfsr_m = Seed;
    @(posedge clk); #1;
    run_txn(2'b01, d, '0, 1'b0, 32'h0, 0);
    check("after_rst_byte0", 128'(last_mask[7:0]), 128'(Seed[7:0]));

    for (int k = 0; k < 10; k++) begin
      logic sv;
      logic [31:0] s;
      logic [1:0] op;
      op = 2'($urandom_range(0, 3));
      sv = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_txn(op, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, sv, s, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
